// File: rtl/alu_pkg.sv
// Shared definitions for the 8085-style ALU execution unit.
// Optional feature macro: ALU_AUX_CARRY_EN (aux-carry flag output and DAA opcode).
package alu_pkg;

    // Operand/result width; flag rules assume 8 bits
    localparam int ALU_DATA_W = 8;

    // Opcode encodings
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_ADC = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_SBB = 4'h3;
    localparam logic [3:0] OP_ANA = 4'h4;
    localparam logic [3:0] OP_XRA = 4'h5;
    localparam logic [3:0] OP_ORA = 4'h6;
    localparam logic [3:0] OP_CMP = 4'h7;
    localparam logic [3:0] OP_INR = 4'h8;
    localparam logic [3:0] OP_DCR = 4'h9;
    localparam logic [3:0] OP_RLC = 4'hA;
    localparam logic [3:0] OP_RRC = 4'hB;
    localparam logic [3:0] OP_RAL = 4'hC;
    localparam logic [3:0] OP_RAR = 4'hD;
    localparam logic [3:0] OP_DAA = 4'hE;
    localparam logic [3:0] OP_NOP = 4'hF;

    // Handshake FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Even parity: 1 when the vector holds an even number of ones
    function automatic logic parity_even(input logic [ALU_DATA_W-1:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/alu_exec_unit_flag_gen.sv
// Combinational Z/P/S flag derivation from a result value.
// Optional feature macro: ALU_AUX_CARRY_EN (not used in this file).
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              parity,
    output logic              sign
);

    // Flags are pure functions of the value presented
    always_comb begin
        zero   = (result == '0);
        parity = parity_even(result);
        sign   = result[DATA_W-1];
    end

endmodule

// File: rtl/alu_exec_unit.sv
// 8-bit 8085-style ALU execution unit with start/done handshake.
// Operands latch on the start edge, compute in EXEC, results/flags register
// on the EXEC->DONE edge and hold until the next completed operation.
// Optional feature macro: ALU_AUX_CARRY_EN adds is_aux_carry and the DAA opcode;
// without it opcode E behaves as NOP.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic              carry_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              is_zero,
    output logic              is_parity,
    output logic              is_sign,
`ifdef ALU_AUX_CARRY_EN
    output logic              is_aux_carry,
`endif
    output logic              is_carry
);

    state_t            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              cin_q, cin_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              z_q, z_d;
    logic              p_q, p_d;
    logic              s_q, s_d;
    logic              cy_q, cy_d;
    logic              ac_q, ac_d;

    // Datapath intermediates
    logic              c_use;
    logic [DATA_W:0]   add_w, sub_w;
    logic [4:0]        add_n, sub_n;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] flag_src;
    logic              cy_n, ac_n, upd_zsp;
    logic              fz, fp, fs;
`ifdef ALU_AUX_CARRY_EN
    logic              daa_lo, daa_hi;
    logic [DATA_W:0]   daa_s1, daa_s2;
`endif

    // Single flag generator; CMP feeds it the difference rather than the result
    alu_flag_gen #(.DATA_W(DATA_W)) u_flag_gen (
        .result (flag_src),
        .zero   (fz),
        .parity (fp),
        .sign   (fs)
    );

    // Arithmetic/logic compute on the latched operands
    always_comb begin
        c_use    = ((op_q == OP_ADC) || (op_q == OP_SBB)) ? cin_q : 1'b0;
        add_w    = {1'b0, a_q} + {1'b0, b_q} + {{DATA_W{1'b0}}, c_use};
        sub_w    = {1'b0, a_q} - {1'b0, b_q} - {{DATA_W{1'b0}}, c_use};
        add_n    = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, c_use};
        sub_n    = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'b0, c_use};
        res      = a_q;
        cy_n     = cy_q;
        ac_n     = ac_q;
        upd_zsp  = 1'b0;
`ifdef ALU_AUX_CARRY_EN
        // Low correction may carry into the high nibble before it is judged
        daa_lo   = (a_q[3:0] > 4'd9) || ac_q;
        daa_s1   = {1'b0, a_q} + (daa_lo ? (DATA_W+1)'(9'h006) : '0);
        daa_hi   = (daa_s1[7:4] > 4'd9) || daa_s1[DATA_W] || cin_q;
        daa_s2   = daa_s1 + (daa_hi ? (DATA_W+1)'(9'h060) : '0);
`endif
        unique case (op_q)
            OP_ADD, OP_ADC: begin
                res = add_w[DATA_W-1:0]; cy_n = add_w[DATA_W]; ac_n = add_n[4]; upd_zsp = 1'b1;
            end
            OP_SUB, OP_SBB: begin
                res = sub_w[DATA_W-1:0]; cy_n = sub_w[DATA_W]; ac_n = sub_n[4]; upd_zsp = 1'b1;
            end
            OP_ANA: begin
                res = a_q & b_q; cy_n = 1'b0; ac_n = 1'b0; upd_zsp = 1'b1;
            end
            OP_XRA: begin
                res = a_q ^ b_q; cy_n = 1'b0; ac_n = 1'b0; upd_zsp = 1'b1;
            end
            OP_ORA: begin
                res = a_q | b_q; cy_n = 1'b0; ac_n = 1'b0; upd_zsp = 1'b1;
            end
            OP_CMP: begin
                cy_n = sub_w[DATA_W]; ac_n = sub_n[4]; upd_zsp = 1'b1;
            end
            OP_INR: begin
                res = a_q + 1'b1; cy_n = cin_q; ac_n = (a_q[3:0] == 4'hF); upd_zsp = 1'b1;
            end
            OP_DCR: begin
                res = a_q - 1'b1; cy_n = cin_q; ac_n = (a_q[3:0] == 4'h0); upd_zsp = 1'b1;
            end
            OP_RLC: begin
                res = {a_q[DATA_W-2:0], a_q[DATA_W-1]}; cy_n = a_q[DATA_W-1];
            end
            OP_RRC: begin
                res = {a_q[0], a_q[DATA_W-1:1]}; cy_n = a_q[0];
            end
            OP_RAL: begin
                res = {a_q[DATA_W-2:0], cin_q}; cy_n = a_q[DATA_W-1];
            end
            OP_RAR: begin
                res = {cin_q, a_q[DATA_W-1:1]}; cy_n = a_q[0];
            end
`ifdef ALU_AUX_CARRY_EN
            OP_DAA: begin
                res     = daa_s2[DATA_W-1:0];
                cy_n    = daa_hi;
                ac_n    = daa_lo && (a_q[3:0] > 4'd9);
                upd_zsp = 1'b1;
            end
`endif
            default: begin
                res = a_q;
            end
        endcase
        flag_src = (op_q == OP_CMP) ? sub_w[DATA_W-1:0] : res;
    end

    // Next-state, operand capture and result/flag update
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        result_d = result_q;
        z_d      = z_q;
        p_d      = p_q;
        s_d      = s_q;
        cy_d     = cy_q;
        ac_d     = ac_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_EXEC;
                    op_d    = opcode;
                    a_d     = operand_a;
                    b_d     = operand_b;
                    cin_d   = carry_in;
                end
            end
            S_EXEC: begin
                state_d  = S_DONE;
                result_d = res;
                cy_d     = cy_n;
                ac_d     = ac_n;
                if (upd_zsp) begin
                    z_d = fz;
                    p_d = fp;
                    s_d = fs;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, operand and output registers; async active-low reset aborts any op
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            result_q <= '0;
            z_q      <= 1'b0;
            p_q      <= 1'b0;
            s_q      <= 1'b0;
            cy_q     <= 1'b0;
            ac_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            result_q <= result_d;
            z_q      <= z_d;
            p_q      <= p_d;
            s_q      <= s_d;
            cy_q     <= cy_d;
            ac_q     <= ac_d;
        end
    end

    // Handshake and output mapping
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        result    = result_q;
        is_zero   = z_q;
        is_parity = p_q;
        is_sign   = s_q;
        is_carry  = cy_q;
`ifdef ALU_AUX_CARRY_EN
        is_aux_carry = ac_q;
`endif
    end

endmodule
